gate_truth_checker: RTL and testbench
=====================================

// Module: gate_truth_checker
// PURPOSE
//  Stimulus/check end of the 2-input gate interface: drives inA/inB into a gate-under-test.
//  Walks all four input vectors, waits a settle time, samples the AND/OR/NOT results,
//  compares them against the ideal truth table and reports pass/fail per vector.
//  Sits beside the NAND-built gate block on the lab board wrapper. Board switches start a run; LEDs show the result.
// PARAMETERS
//  SETTLE_CYCLES  2  idle cycles between applying a vector and sampling results; legal range 0..15
// PORTS
//  clk          input   1  single clock, all state on rising edge
//  reset        input   1  synchronous, active-high; clears all state
//  inStart      input   1  run request, sampled only in IDLE
//  inAND        input   1  AND result from gate-under-test
//  inOR         input   1  OR result from gate-under-test
//  inNOT        input   1  NOT(inA) result from gate-under-test
//  outA         output  1  stimulus A to gate-under-test (vector bit 1)
//  outB         output  1  stimulus B to gate-under-test (vector bit 0)
//  outBusy      output  1  high while a run is in progress
//  outDone      output  1  one-cycle pulse when a run finishes
//  outPass      output  1  high after a run with zero mismatches; held until next start
//  outErrCount  output  3  number of failing vectors in last run (0..4)
//  outFailVec   output  4  bit v set if vector v = {A,B} failed
// BEHAVIOUR
//  Reset: state IDLE; outA=0, outB=0, outBusy=0, outDone=0, outPass=0, outErrCount=0, outFailVec=0.
//  FSM: IDLE -> APPLY -> SETTLE -> CHECK -> (APPLY | DONE) -> IDLE.
//   IDLE: inStart=1 -> clear outPass/outErrCount/outFailVec, vec=0, go APPLY.
//   APPLY (1 cycle): outA/outB take vec bits; outBusy=1.
//   SETTLE (SETTLE_CYCLES cycles): stimulus held; skipped when SETTLE_CYCLES=0.
//   CHECK (1 cycle): vector fails if inAND!=A&B, inOR!=A|B or inNOT!=~A.
//    On failure: outFailVec[vec]=1, outErrCount+1. vec==3 -> DONE, else vec+1 -> APPLY.
//   DONE (1 cycle): outDone=1, outBusy=0, outPass=(outErrCount==0), go IDLE.
//  Latency: start sampled at edge k -> outDone high in cycle k+4*(SETTLE_CYCLES+2)+1.
//  outA/outB hold their last vector in IDLE/DONE; they change only in APPLY.
//  inStart while not in IDLE is ignored (no queuing). inStart held high re-triggers on the IDLE cycle after DONE.
//  One error count per vector, not per output; 2-bit vec counter wraps only via the DONE path.
//  reset mid-run: next cycle is IDLE with all outputs at reset values; no outDone pulse.
//  reset and inStart in the same cycle: reset wins.
// CONFIGURATION
//  CHECKER_STOP_ON_FAIL_EN defined: the first failing CHECK goes straight to DONE.
//   outErrCount=1 and outFailVec has exactly one bit set; remaining vectors are not applied.
//  Undefined: all four vectors are always applied and checked.
// STRUCTURE
//  Shared package gate_chk_pkg: FSM state encoding (IDLE, APPLY, SETTLE, CHECK, DONE),
//   NUM_VECTORS=4, and the SETTLE counter width constant.
//  Sub-module gate_ref_model: combinational ideal AND/OR/NOT for {A,B}, used in CHECK.
//  Top holds the FSM, vec counter, settle counter and result registers.
// TESTING
//  1 Good gates (NAND-built), SETTLE_CYCLES=2, pulse inStart -> outDone 17 cycles later;
//    outPass=1, outErrCount=0, outFailVec=4'b0000; outA/outB seen 00,01,10,11.
//  2 inOR stuck at 0 -> outErrCount=3, outFailVec=4'b1110, outPass=0.
//  3 SETTLE_CYCLES=0, good gates -> outDone 9 cycles after start; outBusy high for 8 cycles.
//  4 inStart pulsed again during SETTLE of vec 1 -> ignored; a single outDone; results same as test 1.
//  5 reset asserted in CHECK of vec 2 -> next cycle IDLE, all outputs 0, no outDone.
//    A new start then runs cleanly.
//  6 CHECKER_STOP_ON_FAIL_EN defined, inNOT stuck at 0 -> fails at vec 0; outDone 5 cycles
//    after start (SETTLE_CYCLES=2); outErrCount=1, outFailVec=4'b0001.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the 2-input gate truth-table checker:
// FSM state encoding, vector count and counter widths.
package gate_chk_pkg;

  localparam int NUM_VECTORS  = 4;
  localparam int VEC_W        = 2;
  localparam int SETTLE_CNT_W = 4;
  localparam int ERR_CNT_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } chkState_t;

endpackage

// File: rtl/gate_ref_model.sv
// Ideal AND/OR/NOT reference for one {A,B} stimulus vector.
// Purely combinational; the checker compares the gate-under-test against it.
module gate_ref_model (
  input  logic a,
  input  logic b,
  output logic expAnd,
  output logic expOr,
  output logic expNot
);

  // Ideal truth table for the current stimulus vector
  always_comb begin
    expAnd = a & b;
    expOr  = a | b;
    expNot = ~a;
  end

endmodule

// File: rtl/gate_truth_checker.sv
// Stimulus/check end of the 2-input gate interface. Walks the four {A,B}
// vectors, waits SETTLE_CYCLES, compares AND/OR/NOT against the ideal
// truth table and latches pass/fail results. All outputs are registered.
// Optional build macro: CHECKER_STOP_ON_FAIL_EN ends the run at the first
// failing vector instead of applying all four.
module gate_truth_checker
  import gate_chk_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   inStart,
  input  logic                   inAND,
  input  logic                   inOR,
  input  logic                   inNOT,
  output logic                   outA,
  output logic                   outB,
  output logic                   outBusy,
  output logic                   outDone,
  output logic                   outPass,
  output logic [ERR_CNT_W-1:0]   outErrCount,
  output logic [NUM_VECTORS-1:0] outFailVec
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST =
    SETTLE_CNT_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
  localparam logic [VEC_W-1:0]        LAST_VEC    = VEC_W'(NUM_VECTORS - 1);
  localparam logic [NUM_VECTORS-1:0]  VEC0_BIT    = {{(NUM_VECTORS-1){1'b0}}, 1'b1};

  chkState_t                state_r,     stateNext_s;
  logic [VEC_W-1:0]         vec_r,       vecNext_s;
  logic [SETTLE_CNT_W-1:0]  settleCnt_r, settleNext_s;
  logic                     outA_r,      aNext_s;
  logic                     outB_r,      bNext_s;
  logic                     busy_r,      busyNext_s;
  logic                     done_r,      doneNext_s;
  logic                     pass_r,      passNext_s;
  logic [ERR_CNT_W-1:0]     errCount_r,  errNext_s;
  logic [NUM_VECTORS-1:0]   failVec_r,   failNext_s;

  logic expAnd_s, expOr_s, expNot_s, vecFail_s;

  gate_ref_model uRefModel (
    .a      (vec_r[1]),
    .b      (vec_r[0]),
    .expAnd (expAnd_s),
    .expOr  (expOr_s),
    .expNot (expNot_s)
  );

  // One error per vector regardless of how many outputs disagree
  always_comb begin
    vecFail_s = (inAND != expAnd_s) || (inOR != expOr_s) || (inNOT != expNot_s);
  end

  // Next-state and next-output logic; registers hold unless a state acts
  always_comb begin
    stateNext_s  = state_r;
    vecNext_s    = vec_r;
    settleNext_s = settleCnt_r;
    aNext_s      = outA_r;
    bNext_s      = outB_r;
    busyNext_s   = busy_r;
    doneNext_s   = 1'b0;
    passNext_s   = pass_r;
    errNext_s    = errCount_r;
    failNext_s   = failVec_r;
    case (state_r)
      ST_IDLE: begin
        if (inStart) begin
          passNext_s  = 1'b0;
          errNext_s   = {ERR_CNT_W{1'b0}};
          failNext_s  = {NUM_VECTORS{1'b0}};
          vecNext_s   = {VEC_W{1'b0}};
          stateNext_s = ST_APPLY;
        end else begin
          stateNext_s = ST_IDLE;
        end
      end
      ST_APPLY: begin
        aNext_s    = vec_r[1];
        bNext_s    = vec_r[0];
        busyNext_s = 1'b1;
        if (SETTLE_CYCLES == 0) begin
          stateNext_s = ST_CHECK;
        end else begin
          settleNext_s = SETTLE_LAST;
          stateNext_s  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settleCnt_r == {SETTLE_CNT_W{1'b0}}) begin
          stateNext_s = ST_CHECK;
        end else begin
          settleNext_s = settleCnt_r - {{(SETTLE_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_CHECK: begin
        if (vecFail_s) begin
          failNext_s = failVec_r | (VEC0_BIT << vec_r);
          errNext_s  = errCount_r + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
        end else begin
          failNext_s = failVec_r;
        end
`ifdef CHECKER_STOP_ON_FAIL_EN
        if (vecFail_s || (vec_r == LAST_VEC)) begin
          stateNext_s = ST_DONE;
        end else begin
          vecNext_s   = vec_r + {{(VEC_W-1){1'b0}}, 1'b1};
          stateNext_s = ST_APPLY;
        end
`else
        if (vec_r == LAST_VEC) begin
          stateNext_s = ST_DONE;
        end else begin
          vecNext_s   = vec_r + {{(VEC_W-1){1'b0}}, 1'b1};
          stateNext_s = ST_APPLY;
        end
`endif
      end
      ST_DONE: begin
        doneNext_s  = 1'b1;
        busyNext_s  = 1'b0;
        passNext_s  = (errCount_r == {ERR_CNT_W{1'b0}});
        stateNext_s = ST_IDLE;
      end
      default: begin
        stateNext_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      vec_r       <= {VEC_W{1'b0}};
      settleCnt_r <= {SETTLE_CNT_W{1'b0}};
      outA_r      <= 1'b0;
      outB_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      errCount_r  <= {ERR_CNT_W{1'b0}};
      failVec_r   <= {NUM_VECTORS{1'b0}};
    end else begin
      state_r     <= stateNext_s;
      vec_r       <= vecNext_s;
      settleCnt_r <= settleNext_s;
      outA_r      <= aNext_s;
      outB_r      <= bNext_s;
      busy_r      <= busyNext_s;
      done_r      <= doneNext_s;
      pass_r      <= passNext_s;
      errCount_r  <= errNext_s;
      failVec_r   <= failNext_s;
    end
  end

  assign outA        = outA_r;
  assign outB        = outB_r;
  assign outBusy     = busy_r;
  assign outDone     = done_r;
  assign outPass     = pass_r;
  assign outErrCount = errCount_r;
  assign outFailVec  = failVec_r;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Directed self-checking bench for gate_truth_checker. A NAND-built gate
// model with stuck-at controls stands in for the gate-under-test.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, inStart, start0;
  logic       orStuck, notStuck;
  logic       outA, outB, outBusy, outDone, outPass;
  logic [2:0] outErrCount;
  logic [3:0] outFailVec;
  logic       outA0, outB0, outBusy0, outDone0, outPass0;
  logic [2:0] outErrCount0;
  logic [3:0] outFailVec0;
  logic       gAnd, gOr, gNot, gAnd0, gOr0, gNot0;

  int checks = 0;
  int errors = 0;

  function automatic logic nand2(input logic a, input logic b);
    return ~(a & b);
  endfunction

  // NAND-built gates under test, with injectable stuck-at faults
  always_comb begin
    gAnd  = nand2(nand2(outA, outB), nand2(outA, outB));
    gOr   = orStuck  ? 1'b0 : nand2(nand2(outA, outA), nand2(outB, outB));
    gNot  = notStuck ? 1'b0 : nand2(outA, outA);
    gAnd0 = nand2(nand2(outA0, outB0), nand2(outA0, outB0));
    gOr0  = nand2(nand2(outA0, outA0), nand2(outB0, outB0));
    gNot0 = nand2(outA0, outA0);
  end

  gate_truth_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .inStart(inStart),
    .inAND(gAnd), .inOR(gOr), .inNOT(gNot),
    .outA(outA), .outB(outB), .outBusy(outBusy), .outDone(outDone),
    .outPass(outPass), .outErrCount(outErrCount), .outFailVec(outFailVec)
  );

  gate_truth_checker #(.SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .inStart(start0),
    .inAND(gAnd0), .inOR(gOr0), .inNOT(gNot0),
    .outA(outA0), .outB(outB0), .outBusy(outBusy0), .outDone(outDone0),
    .outPass(outPass0), .outErrCount(outErrCount0), .outFailVec(outFailVec0)
  );

  // Pulse start on dut and observe for a window; count 0 is the negedge after the start edge
  task automatic runObserve(input int extraStartAt, input int resetAt, input int window,
                            output int doneCycle, output int doneCount,
                            output int seqLen, output logic [7:0] seq,
                            output logic [11:0] snap);
    logic [1:0] last;
    doneCycle = -1; doneCount = 0; seqLen = 0; seq = 8'h00; snap = 12'h000; last = 2'b00;
    @(negedge clk) inStart = 1'b1;
    @(negedge clk) inStart = 1'b0;
    for (int c = 1; c <= window; c++) begin
      @(negedge clk);
      if (outDone) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
      if (outBusy && (seqLen == 0 || {outA, outB} != last)) begin
        seq = {seq[5:0], outA, outB};
        last = {outA, outB};
        seqLen++;
      end
      if (c == resetAt + 1) snap = {outA, outB, outBusy, outDone, outPass, outErrCount, outFailVec};
      inStart = (c == extraStartAt);
      reset   = (c == resetAt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; inStart = 1'b1; start0 = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({outA, outB, outBusy, outDone, outPass, outErrCount, outFailVec} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 000", {outA, outB, outBusy, outDone, outPass, outErrCount, outFailVec});
    end
    checks++;
    if ({outA0, outB0, outBusy0, outDone0, outPass0, outErrCount0, outFailVec0} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs0: got %h want 000", {outA0, outB0, outBusy0, outDone0, outPass0, outErrCount0, outFailVec0});
    end
    reset = 1'b0; inStart = 1'b0; start0 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outBusy !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins_start: busy got %b want 0", outBusy);
    end
  endtask

  task automatic test_good_gates();
    int dc, dn, sl; logic [7:0] sq; logic [11:0] sn;
    runObserve(-1, -1, 30, dc, dn, sl, sq, sn);
    checks++;
    if (dc !== 17) begin errors++; $display("FAIL good_latency: got %0d want 17", dc); end
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL good_done_count: got %0d want 1", dn); end
    checks++;
    if (sl !== 4 || sq !== 8'b00_01_10_11) begin
      errors++; $display("FAIL good_vector_order: got len %0d seq %b want 4 00011011", sl, sq);
    end
    checks++;
    if ({outPass, outErrCount, outFailVec} !== {1'b1, 3'd0, 4'b0000}) begin
      errors++; $display("FAIL good_results: got pass %b err %0d fv %b want 1 0 0000", outPass, outErrCount, outFailVec);
    end
  endtask

  task automatic test_or_stuck();
    int dc, dn, sl; logic [7:0] sq; logic [11:0] sn;
    orStuck = 1'b1;
    runObserve(-1, -1, 30, dc, dn, sl, sq, sn);
    orStuck = 1'b0;
    checks++;
    if ({outPass, outErrCount, outFailVec} !== {1'b0, 3'd3, 4'b1110}) begin
      errors++; $display("FAIL or_stuck_results: got pass %b err %0d fv %b want 0 3 1110", outPass, outErrCount, outFailVec);
    end
    checks++;
    if (dc !== 17) begin errors++; $display("FAIL or_stuck_latency: got %0d want 17", dc); end
  endtask

  task automatic test_settle_zero();
    int dc, busyCnt;
    dc = -1; busyCnt = 0;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (outBusy0) busyCnt++;
      if (outDone0 && dc < 0) dc = c;
    end
    checks++;
    if (dc !== 9) begin errors++; $display("FAIL settle0_latency: got %0d want 9", dc); end
    checks++;
    if (busyCnt !== 8) begin errors++; $display("FAIL settle0_busy_cycles: got %0d want 8", busyCnt); end
    checks++;
    if ({outPass0, outErrCount0, outFailVec0} !== {1'b1, 3'd0, 4'b0000}) begin
      errors++; $display("FAIL settle0_results: got pass %b err %0d fv %b want 1 0 0000", outPass0, outErrCount0, outFailVec0);
    end
  endtask

  task automatic test_start_ignored();
    int dc, dn, sl; logic [7:0] sq; logic [11:0] sn;
    runObserve(5, -1, 30, dc, dn, sl, sq, sn);
    checks++;
    if (dc !== 17 || dn !== 1) begin
      errors++; $display("FAIL ignore_start: got done at %0d count %0d want 17 1", dc, dn);
    end
    checks++;
    if ({outPass, outErrCount, outFailVec} !== {1'b1, 3'd0, 4'b0000}) begin
      errors++; $display("FAIL ignore_start_results: got pass %b err %0d fv %b want 1 0 0000", outPass, outErrCount, outFailVec);
    end
  endtask

  task automatic test_reset_midrun();
    int dc, dn, sl; logic [7:0] sq; logic [11:0] sn;
    orStuck = 1'b1;
    runObserve(-1, 11, 30, dc, dn, sl, sq, sn);
    orStuck = 1'b0;
    checks++;
    if (sn !== 12'h000) begin errors++; $display("FAIL midrun_reset_outputs: got %h want 000", sn); end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL midrun_reset_no_done: got %0d pulses want 0", dn); end
    runObserve(-1, -1, 30, dc, dn, sl, sq, sn);
    checks++;
    if (dc !== 17 || {outPass, outErrCount, outFailVec} !== {1'b1, 3'd0, 4'b0000}) begin
      errors++; $display("FAIL midrun_rerun: got done %0d pass %b err %0d fv %b want 17 1 0 0000", dc, outPass, outErrCount, outFailVec);
    end
  endtask

  task automatic test_not_stuck();
    int dc, dn, sl; logic [7:0] sq; logic [11:0] sn;
    int expDc, expLen; logic [2:0] expErr; logic [3:0] expFv;
`ifdef CHECKER_STOP_ON_FAIL_EN
    expDc = 5;  expLen = 1; expErr = 3'd1; expFv = 4'b0001;
`else
    expDc = 17; expLen = 4; expErr = 3'd2; expFv = 4'b0011;
`endif
    notStuck = 1'b1;
    runObserve(-1, -1, 30, dc, dn, sl, sq, sn);
    notStuck = 1'b0;
    checks++;
    if (dc !== expDc) begin errors++; $display("FAIL not_stuck_latency: got %0d want %0d", dc, expDc); end
    checks++;
    if ({outPass, outErrCount, outFailVec} !== {1'b0, expErr, expFv}) begin
      errors++; $display("FAIL not_stuck_results: got pass %b err %0d fv %b want 0 %0d %b", outPass, outErrCount, outFailVec, expErr, expFv);
    end
    checks++;
    if (sl !== expLen) begin errors++; $display("FAIL not_stuck_vectors: got %0d want %0d", sl, expLen); end
  endtask

  task automatic test_back_to_back();
    int first, second, cnt;
    first = -1; second = -1; cnt = 0;
    @(negedge clk) inStart = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (outDone) begin
        cnt++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (c == 18) inStart = 1'b0;
    end
    inStart = 1'b0;
    checks++;
    if (cnt !== 2 || first !== 17 || second !== 35) begin
      errors++; $display("FAIL back_to_back: got %0d pulses at %0d,%0d want 2 at 17,35", cnt, first, second);
    end
  endtask

  initial begin
    reset = 1'b1; inStart = 1'b0; start0 = 1'b0; orStuck = 1'b0; notStuck = 1'b0;
    test_reset();
    test_good_gates();
    test_or_stuck();
    test_settle_zero();
    test_start_ignored();
    test_reset_midrun();
    test_not_stuck();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
